// File: rtl/dualedge_pkg.sv
// Shared mode encodings and edge-enable decode for the dual-edge pipeline.
package dualedge_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_POS  = 2'b01,
        MODE_NEG  = 2'b10,
        MODE_BOTH = 2'b11
    } mode_e;

    function automatic logic mode_pos_en(input logic [1:0] m);
        return (m == MODE_POS) || (m == MODE_BOTH);
    endfunction

    function automatic logic mode_neg_en(input logic [1:0] m);
        return (m == MODE_NEG) || (m == MODE_BOTH);
    endfunction

endpackage

// File: rtl/dualedge_ff.sv
// Dual-edge register: a rising bank and a falling bank whose XOR is the stored value,
// so each edge updates only its own bank without touching the clock.
module dualedge_ff #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             areset_n,
    input  logic             pos_en,
    input  logic             neg_en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] pos_q;
    logic [WIDTH-1:0] neg_q;

    // Each bank stores d XOR the other bank so that pos_q ^ neg_q == d after its edge.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            pos_q <= '0;
        end else if (pos_en) begin
            pos_q <= d ^ neg_q;
        end
    end

    always_ff @(negedge clk or negedge areset_n) begin
        if (!areset_n) begin
            neg_q <= '0;
        end else if (neg_en) begin
            neg_q <= d ^ pos_q;
        end
    end

    assign q = pos_q ^ neg_q;

endmodule

// File: rtl/dualedge_pipe.sv
// Dual-edge delay line of DEPTH stages with fill tracking; optional edge counter
// enabled by the DUALEDGE_PIPE_CNT_EN macro.
module dualedge_pipe
    import dualedge_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             areset_n,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             primed
`ifdef DUALEDGE_PIPE_CNT_EN
    ,
    output logic [CNT_W-1:0] edge_cnt
`endif
);

    localparam int unsigned FillW = $clog2(DEPTH + 1);

    if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
        $error("dualedge_pipe: WIDTH must be 1..64");
    end
    if (DEPTH < 1 || DEPTH > 16) begin : g_bad_depth
        $error("dualedge_pipe: DEPTH must be 1..16");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("dualedge_pipe: CNT_W must be at least 1");
    end

    // mode is sampled by every bank at its own edge, so a mode change only
    // affects edges after it has settled.
    logic pos_en;
    logic neg_en;

    assign pos_en = mode_pos_en(mode);
    assign neg_en = mode_neg_en(mode);

    logic [WIDTH-1:0] stage_q [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic [WIDTH-1:0] stage_d;

        if (i == 0) begin : g_head
            assign stage_d = d;
        end else begin : g_link
            assign stage_d = stage_q[i-1];
        end

        dualedge_ff #(
            .WIDTH (WIDTH)
        ) u_ff (
            .clk      (clk),
            .areset_n (areset_n),
            .pos_en   (pos_en),
            .neg_en   (neg_en),
            .d        (stage_d),
            .q        (stage_q[i])
        );
    end

    assign q = stage_q[DEPTH-1];

    logic [FillW-1:0] fill_q;
    logic [FillW-1:0] fill_d;
    logic             fill_full;

    assign fill_full = (fill_q == FillW'(DEPTH));

    always_comb begin
        fill_d = fill_q;
        if (!fill_full) begin
            fill_d = fill_q + FillW'(1);
        end
    end

    dualedge_ff #(
        .WIDTH (FillW)
    ) u_fill (
        .clk      (clk),
        .areset_n (areset_n),
        .pos_en   (pos_en),
        .neg_en   (neg_en),
        .d        (fill_d),
        .q        (fill_q)
    );

    // Fill count saturates, so primed stays high until the next reset.
    assign primed = fill_full;

`ifdef DUALEDGE_PIPE_CNT_EN
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign cnt_d = cnt_q + CNT_W'(1);

    dualedge_ff #(
        .WIDTH (CNT_W)
    ) u_cnt (
        .clk      (clk),
        .areset_n (areset_n),
        .pos_en   (pos_en),
        .neg_en   (neg_en),
        .d        (cnt_d),
        .q        (cnt_q)
    );

    assign edge_cnt = cnt_q;
`endif

endmodule

// File: doc/dualedge_pipe.md
DUALEDGE_PIPE -- requirements
Module: dualedge_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data width in bits (1..64).
REQ-002 SHALL have parameter DEPTH, default 4, number of dual-edge stages (1..16).
REQ-003 SHALL have parameter CNT_W, default 16, width of the edge counter (see REQ-020).
REQ-004 SHALL have port clk  input  1  single clock; both edges are active.
REQ-005 SHALL have port areset_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port mode  input  2  edge select: 00 HOLD, 01 POS, 10 NEG, 11 BOTH.
REQ-007 SHALL have port d  input  WIDTH  data sampled on active edges.
REQ-008 SHALL have port q  output  WIDTH  d delayed by DEPTH active edges.
REQ-009 SHALL have port primed  output  1  high once DEPTH active edges have occurred since reset.

Function
REQ-010 SHALL define the active edges per mode: POS = rising only; NEG = falling only; BOTH = rising and falling; HOLD = none.
REQ-011 SHALL sample mode at each clock edge; an edge is active only if mode sampled at that edge enables it; no glitch on mode-change edges.
REQ-012 SHALL shift the pipeline on every active edge: stage0 <= d; stage i <= stage i-1; q = stage DEPTH-1.
REQ-013 SHALL give q, after k >= DEPTH active edges, the value of d sampled at active edge k-DEPTH+1.
REQ-014 SHALL make q change only directly after an active edge (no combinational path d->q or mode->q); q stable in HOLD.
REQ-015 SHALL keep an internal fill count: +1 per active edge, saturating at DEPTH.
REQ-016 SHALL assert primed when the fill count reaches DEPTH and hold it until reset.
REQ-017 SHALL not gate or invert clk in logic; each dual-edge register is a rising bank plus a falling bank combined by XOR (p ^ n); only the bank of the active edge updates.
REQ-018 SHALL keep state unchanged across HOLD periods of any length; shifting resumes at the next active edge.

Reset
REQ-019 SHALL, while areset_n = 0, force all stage registers, q, fill count and primed (and edge_cnt if present) to 0 immediately, independent of clk; edges are ignored during reset; after release, the first active edge is counted as edge 1; reset mid-operation discards all data.

Configuration
REQ-020 SHALL honour macro DUALEDGE_PIPE_CNT_EN: if defined, add output edge_cnt [CNT_W-1:0] counting active edges since reset, wrapping 2^CNT_W-1 -> 0, updated on the same edges as the pipeline; if undefined, the port and counter are absent and all other behaviour is unchanged.

Structure
REQ-021 SHALL place the mode encodings (MODE_HOLD, MODE_POS, MODE_NEG, MODE_BOTH) and the mode typedef in shared package dualedge_pkg.
REQ-022 SHALL implement each stage with one sub-module, dualedge_ff: WIDTH-bit, with pos_en and neg_en inputs and async active-low reset; the fill count and edge_cnt reuse dualedge_ff.

Verification
REQ-023 SHALL cover: WIDTH=8, DEPTH=4, mode=BOTH, d=1,2,3,... on consecutive edges -> q=1 after 4th edge, then q increments every half-cycle; primed rises at 4th edge.
REQ-024 SHALL cover: mode=POS, d changed on both edges -> only rising-edge samples appear on q, 4 rising edges latency; falling-edge values never appear.
REQ-025 SHALL cover: mode=BOTH for 2 edges, HOLD for 10 cycles, then BOTH -> q, primed and fill frozen during HOLD; primed rises at 4th active edge overall.
REQ-026 SHALL cover: areset_n pulsed low mid-half-cycle after primed -> q=0, primed=0 immediately; refill needs 4 new active edges.
REQ-027 SHALL cover: mode NEG->BOTH switched just before a rising edge -> that rising edge is active; compare against a reference model over 200 random edges with zero mismatches.
REQ-028 SHALL cover: with DUALEDGE_PIPE_CNT_EN, CNT_W=4, mode=BOTH for 17 edges -> edge_cnt wraps 15->0 and reads 1.
